cram_loader: RTL and testbench

//  Feeds the serial CRAM configuration chain that runs through the IO ring and fabric tiles.

---
 rtl/cram_loader.sv | 168 ++++++++++++++++
 tb/tb_cram_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_loader.sv
// cram_loader: streams config words MSB-first into the serial CRAM chain,
// keeps a CRC-16 of the written bits and optionally verifies by full rotation.
module cram_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 384,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              config_en,
    output logic              config_data_in,
    input  logic              config_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       crc
);

    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN       = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_FULL   = BC_W'(WORD_W);
    localparam logic [15:0]      POLY      = 16'h1021;
    localparam logic [15:0]      CRC_INIT  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  rot_cnt_q, rot_cnt_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic [CNT_W-1:0]  take;
    logic [WORD_W-1:0] wbuf_q, wbuf_d;
    logic [BC_W-1:0]   buf_cnt_q, buf_cnt_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       crc_rd_q, crc_rd_d;
    logic [15:0]       crc_rd_nx;
    logic              pass_q, pass_d;
    logic              verify_q, verify_d;
    logic              shift_bit;
    logic              fb;
    logic              fb_rd;

    // Next-state, datapath and output decode for the load/verify sequencer
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rot_cnt_d = rot_cnt_q;
        left_d    = left_q;
        wbuf_d    = wbuf_q;
        buf_cnt_d = buf_cnt_q;
        crc_d     = crc_q;
        crc_rd_d  = crc_rd_q;
        pass_d    = pass_q;
        verify_d  = verify_q;

        wr_ready       = 1'b0;
        config_en      = 1'b0;
        config_data_in = 1'b0;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);

        shift_bit = wbuf_q[WORD_W-1];
        fb        = crc_q[15] ^ shift_bit;
        fb_rd     = crc_rd_q[15] ^ config_data_out;
        crc_rd_nx = {crc_rd_q[14:0], 1'b0} ^ (fb_rd ? POLY : 16'h0000);
        take      = (left_q >= WORD_BITS) ? WORD_BITS : left_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    bit_cnt_d = '0;
                    rot_cnt_d = '0;
                    left_d    = LEN;
                    buf_cnt_d = '0;
                    crc_d     = CRC_INIT;
                    crc_rd_d  = CRC_INIT;
                    pass_d    = 1'b0;
                    verify_d  = verify;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_ready = (buf_cnt_q <= BC_ONE) && (left_q != '0);
                if (buf_cnt_q != '0) begin
                    config_en      = 1'b1;
                    config_data_in = shift_bit;
                    wbuf_d         = wbuf_q << 1;
                    buf_cnt_d      = buf_cnt_q - BC_ONE;
                    bit_cnt_d      = bit_cnt_q + CNT_ONE;
                    crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
                    if (bit_cnt_q == LAST) begin
                        rot_cnt_d = '0;
                        state_d   = verify_q ? S_VERIFY : S_DONE;
                    end
                end
                // A word taken while the last buffered bit shifts keeps the stream gap-free
                if (wr_valid && wr_ready) begin
                    wbuf_d    = wr_data;
                    buf_cnt_d = (left_q >= WORD_BITS) ? BC_FULL : BC_W'(left_q);
                    left_d    = left_q - take;
                end
            end
            S_VERIFY: begin
                config_en      = 1'b1;
                config_data_in = config_data_out;
                crc_rd_d       = crc_rd_nx;
                rot_cnt_d      = rot_cnt_q + CNT_ONE;
                if (rot_cnt_q == LAST) begin
                    pass_d  = (crc_rd_nx == crc_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; reset clears results as well
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rot_cnt_q <= '0;
            left_q    <= '0;
            wbuf_q    <= '0;
            buf_cnt_q <= '0;
            crc_q     <= '0;
            crc_rd_q  <= '0;
            pass_q    <= 1'b0;
            verify_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rot_cnt_q <= rot_cnt_d;
            left_q    <= left_d;
            wbuf_q    <= wbuf_d;
            buf_cnt_q <= buf_cnt_d;
            crc_q     <= crc_d;
            crc_rd_q  <= crc_rd_d;
            pass_q    <= pass_d;
            verify_q  <= verify_d;
        end
    end

    assign pass = pass_q;
    assign crc  = crc_q;

endmodule

// File: tb/tb_cram_loader.sv
// tb_cram_loader: directed checks of cram_loader with a behavioural CRAM chain
// on a default-size instance and a 10-bit-chain instance.
module tb_cram_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic verify;
    logic abort;
    logic sel;
    logic corrupt;
    logic mon_clr;
    logic [7:0] wr_data;
    logic wr_valid;

    logic b_ready, b_en, b_din, b_dout, b_busy, b_done, b_pass;
    logic [15:0] b_crc;
    logic s_ready, s_en, s_din, s_dout, s_busy, s_done, s_pass;
    logic [15:0] s_crc;
    logic start_b, start_s, rdy, dn;

    logic [383:0] b_chain = '0;
    logic [9:0]   s_chain = '0;
    logic [7:0]   words [0:63];
    logic [383:0] pat;

    int n_chk = 0;
    int n_fail = 0;
    int en_cnt, run, max_run, hs_cnt, done_cnt, bub_cnt;
    int s_en_cnt, s_ones, s_hs, s_done_cnt;

    always #5 clk = ~clk;

    assign start_b = start & ~sel;
    assign start_s = start & sel;
    assign rdy     = sel ? s_ready : b_ready;
    assign dn      = sel ? s_done : b_done;
    assign b_dout  = b_chain[383] ^ corrupt;
    assign s_dout  = s_chain[9];

    cram_loader u_big (
        .clk(clk), .rst(rst), .start(start_b), .verify(verify),
        .abort(abort), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(b_ready), .config_en(b_en), .config_data_in(b_din),
        .config_data_out(b_dout), .busy(b_busy), .done(b_done),
        .pass(b_pass), .crc(b_crc)
    );

    cram_loader #(.WORD_W(8), .CHAIN_LEN(10)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .verify(verify),
        .abort(abort), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(s_ready), .config_en(s_en), .config_data_in(s_din),
        .config_data_out(s_dout), .busy(s_busy), .done(s_done),
        .pass(s_pass), .crc(s_crc)
    );

    // Behavioural CRAM chains
    always @(posedge clk) begin
        if (b_en) b_chain <= {b_chain[382:0], b_din};
        if (s_en) s_chain <= {s_chain[8:0], s_din};
    end

    // Activity monitors
    always @(posedge clk) begin
        if (mon_clr) begin
            en_cnt <= 0; run <= 0; max_run <= 0; hs_cnt <= 0;
            done_cnt <= 0; bub_cnt <= 0;
            s_en_cnt <= 0; s_ones <= 0; s_hs <= 0; s_done_cnt <= 0;
        end else begin
            if (b_en) begin
                en_cnt <= en_cnt + 1;
                run <= run + 1;
                if (run + 1 > max_run) max_run <= run + 1;
            end else begin
                run <= 0;
            end
            if (wr_valid && b_ready) hs_cnt <= hs_cnt + 1;
            if (b_done) done_cnt <= done_cnt + 1;
            if (b_busy && !b_en && !b_done) bub_cnt <= bub_cnt + 1;
            if (s_en) begin
                s_en_cnt <= s_en_cnt + 1;
                if (s_din) s_ones <= s_ones + 1;
            end
            if (wr_valid && s_ready) s_hs <= s_hs + 1;
            if (s_done) s_done_cnt <= s_done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [383:0] got,
                         input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input logic v, input logic s);
        sel = s;
        verify = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        verify = 1'b0;
    endtask

    // Push words[0..n-1]; optional 5 ready-cycle gap and stray start pulse
    task automatic feed(input int n, input int gap_at, input int pulse_at);
        int k;
        for (int i = 0; i < n; i++) begin
            wr_data = words[i];
            wr_valid = 1'b1;
            k = 0;
            while (!rdy && k < 2000) begin
                tick();
                k++;
            end
            if (!rdy) begin
                check("ready_timeout", rdy, 1);
                wr_valid = 1'b0;
                return;
            end
            tick();
            wr_valid = 1'b0;
            if (i == pulse_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (i == gap_at) begin
                k = 0;
                while (!rdy && k < 100) begin
                    tick();
                    k++;
                end
                repeat (5) tick();
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!dn && k < 3000) begin
            tick();
            k++;
        end
        check(tag, dn, 1);
    endtask

    function automatic logic [15:0] crc_model(input logic [383:0] s,
                                              input int nbits);
        logic [15:0] c;
        logic b;
        c = 16'hFFFF;
        for (int i = nbits - 1; i >= 0; i--) begin
            b = c[15] ^ s[i];
            c = {c[14:0], 1'b0};
            if (b) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [383:0] a5_pat;
        rst = 1'b1; start = 1'b0; verify = 1'b0; abort = 1'b0;
        sel = 1'b0; corrupt = 1'b0; mon_clr = 1'b1;
        wr_data = '0; wr_valid = 1'b0;
        repeat (3) tick();
        check("rst_wr_ready", b_ready, 0);
        check("rst_config_en", b_en, 0);
        check("rst_config_data_in", b_din, 0);
        check("rst_busy", b_busy, 0);
        check("rst_done", b_done, 0);
        check("rst_pass", b_pass, 0);
        check("rst_crc", b_crc, 0);
        rst = 1'b0;
        mon_clr = 1'b0;

        a5_pat = {48{8'hA5}};

        // T1: full load with verify
        for (int i = 0; i < 48; i++) words[i] = 8'hA5;
        clr();
        do_start(1'b1, 1'b0);
        check("t1_busy", b_busy, 1);
        feed(48, -1, -1);
        wait_done("t1_done");
        check("t1_pass", b_pass, 1);
        check("t1_crc", b_crc, crc_model(a5_pat, 384));
        check("t1_en_in_done", b_en, 0);
        tick();
        check("t1_max_run", max_run, 768);
        check("t1_en_cnt", en_cnt, 768);
        check("t1_hs", hs_cnt, 48);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_bubbles", bub_cnt, 1);
        check("t1_chain", b_chain, a5_pat);
        check("t1_idle", b_busy, 0);

        // T2: 10-bit chain, partial last word
        words[0] = 8'hFF;
        words[1] = 8'hC0;
        clr();
        do_start(1'b0, 1'b1);
        feed(2, -1, -1);
        wait_done("t2_done");
        check("t2_crc", s_crc, crc_model(384'h3FF, 10));
        check("t2_ready_low", s_ready, 0);
        check("t2_pass", s_pass, 0);
        tick();
        check("t2_en_cnt", s_en_cnt, 10);
        check("t2_ones", s_ones, 10);
        check("t2_hs", s_hs, 2);
        check("t2_chain", s_chain, 10'h3FF);
        check("t2_done_cnt", s_done_cnt, 1);
        check("t2_ready_after", s_ready, 0);
        sel = 1'b0;

        // T3: one corrupted readback bit
        for (int i = 0; i < 48; i++) words[i] = 8'hA5;
        clr();
        do_start(1'b1, 1'b0);
        feed(48, -1, -1);
        k = 0;
        while (en_cnt < 500 && k < 1000) begin
            tick();
            k++;
        end
        check("t3_in_verify", (en_cnt >= 500), 1);
        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        wait_done("t3_done");
        check("t3_pass", b_pass, 0);
        check("t3_crc", b_crc, crc_model(a5_pat, 384));
        tick();
        check("t3_done_cnt", done_cnt, 1);

        // T4: wr_valid gap after word 10, no verify
        clr();
        do_start(1'b0, 1'b0);
        feed(48, 10, -1);
        wait_done("t4_done");
        check("t4_crc", b_crc, crc_model(a5_pat, 384));
        check("t4_pass", b_pass, 0);
        tick();
        check("t4_en_cnt", en_cnt, 384);
        check("t4_bubbles", bub_cnt, 6);
        check("t4_hs", hs_cnt, 48);
        check("t4_chain", b_chain, a5_pat);

        // T5a: reset in the middle of a load
        for (int i = 0; i < 48; i++) words[i] = 8'(i * 7 + 3);
        clr();
        do_start(1'b0, 1'b0);
        feed(20, -1, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5r_busy", b_busy, 0);
        check("t5r_en", b_en, 0);
        check("t5r_ready", b_ready, 0);
        check("t5r_crc", b_crc, 0);
        check("t5r_pass", b_pass, 0);
        repeat (3) tick();
        check("t5r_no_done", done_cnt, 0);

        // T5b: abort in the middle of a verify run; abort beats start
        clr();
        do_start(1'b1, 1'b0);
        feed(20, -1, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5a_busy", b_busy, 0);
        check("t5a_en", b_en, 0);
        check("t5a_ready", b_ready, 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5a_abort_over_start", b_busy, 0);
        repeat (3) tick();
        check("t5a_no_done", done_cnt, 0);

        // T6: full verify load with a stray start mid-load
        pat = '0;
        for (int i = 0; i < 48; i++) pat = {pat[375:0], words[i]};
        clr();
        do_start(1'b1, 1'b0);
        feed(48, -1, 24);
        wait_done("t6_done");
        check("t6_pass", b_pass, 1);
        check("t6_crc", b_crc, crc_model(pat, 384));
        tick();
        check("t6_done_cnt", done_cnt, 1);
        check("t6_en_cnt", en_cnt, 768);
        check("t6_max_run", max_run, 768);
        check("t6_hs", hs_cnt, 48);
        check("t6_chain", b_chain, pat);
        repeat (3) tick();
        check("t6_single_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
